// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and the CPOL/CPHA mode word.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_DONE
    } spi_state_t;

    // Mode number is {cpol, cpha}, matching the usual SPI mode 0..3 numbering.
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    function automatic spi_mode_t make_mode(input logic cpol, input logic cpha);
        return spi_mode_t'({cpol, cpha});
    endfunction

    function automatic logic mode_cpol(input spi_mode_t m);
        return m[1];
    endfunction

    function automatic logic mode_cpha(input spi_mode_t m);
        return m[0];
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: times each CLK_DIV half-period of a frame and flags the
// leading/trailing SCLK edges; sclk itself is cpol XOR the toggle phase.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic cpol,
    output logic sclk,
    output logic tick,
    output logic last_half,
    output logic lead_stb,
    output logic trail_stb
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_W = $clog2(2 * DATA_W + 3);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] N_EDGES  = HALF_W'(2 * DATA_W);

    logic [DIV_W-1:0]  div_cnt_reg;
    logic [HALF_W-1:0] half_cnt_reg;
    logic              phase_reg;
    logic              edge_stb;

    // half_cnt is 0 in SETUP, 1..2*DATA_W in XFER and 2*DATA_W+1 in HOLD;
    // an edge closes every half-period from SETUP up to the last-but-one of XFER.
    assign tick      = active && (div_cnt_reg == DIV_LAST);
    assign edge_stb  = tick && (half_cnt_reg < N_EDGES);
    assign lead_stb  = edge_stb && !half_cnt_reg[0];
    assign trail_stb = edge_stb && half_cnt_reg[0];
    assign last_half = (half_cnt_reg == N_EDGES);
    assign sclk      = cpol ^ phase_reg;

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            div_cnt_reg  <= '0;
            half_cnt_reg <= '0;
            phase_reg    <= 1'b0;
        end else if (tick) begin
            div_cnt_reg  <= '0;
            half_cnt_reg <= half_cnt_reg + 1'b1;
            if (edge_stb) begin
                phase_reg <= ~phase_reg;
            end
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_multi.sv
// Multi-slave SPI master: per-frame CPOL/CPHA, MSB-first, one frame at a time
// to the slave picked by slave_sel.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int N_SLAVES = 3,
    parameter int CLK_DIV  = 4,
    localparam int SEL_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEL_W-1:0]  slave_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [N_SLAVES-1:0] miso,
    output logic              sclk,
    output logic              mosi,
    output logic [N_SLAVES-1:0] cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam logic [SEL_W:0] N_SEL = (SEL_W + 1)'(N_SLAVES);

    spi_state_t          state_reg, state_next;
    spi_mode_t           mode_reg;
    logic [SEL_W-1:0]    sel_reg;
    logic [DATA_W-1:0]   tx_sr_reg;
    logic [DATA_W-1:0]   rx_sr_reg;
    logic [DATA_W-1:0]   rx_data_reg;
    logic                mosi_reg;
    logic [N_SLAVES-1:0] sel_onehot;
    logic                frame_active;
    logic                accept;
    logic                miso_bit;
    logic                tick, last_half, lead_stb, trail_stb;
    logic                sample_stb, shift_stb;

    assign accept       = (state_reg == ST_IDLE) && start && ({1'b0, slave_sel} < N_SEL);
    assign frame_active = (state_reg == ST_SETUP) || (state_reg == ST_XFER) || (state_reg == ST_HOLD);

    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_cs
        assign sel_onehot[gi] = frame_active && (sel_reg == SEL_W'(gi));
        assign cs_n[gi]       = ~sel_onehot[gi];
    end

    // Only the selected lane can be non-zero after masking, so OR-reduce picks it.
    assign miso_bit   = |(miso & sel_onehot);
    assign sample_stb = mode_cpha(mode_reg) ? trail_stb : lead_stb;
    assign shift_stb  = mode_cpha(mode_reg) ? lead_stb : trail_stb;

    spi_clk_gen #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .active    (frame_active),
        .cpol      (mode_cpol(mode_reg)),
        .sclk      (sclk),
        .tick      (tick),
        .last_half (last_half),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_SETUP;
            ST_SETUP: if (tick) state_next = ST_XFER;
            ST_XFER:  if (tick && last_half) state_next = ST_HOLD;
            ST_HOLD:  if (tick) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg    <= MODE0;
            sel_reg     <= '0;
            tx_sr_reg   <= '0;
            rx_sr_reg   <= '0;
            rx_data_reg <= '0;
            mosi_reg    <= 1'b0;
        end else begin
            if (accept) begin
                mode_reg  <= make_mode(cpol, cpha);
                sel_reg   <= slave_sel;
                rx_sr_reg <= '0;
                // CPHA=0 puts the MSB on the wire before the first edge; CPHA=1 waits for it.
                if (cpha) begin
                    tx_sr_reg <= tx_data;
                    mosi_reg  <= 1'b0;
                end else begin
                    tx_sr_reg <= tx_data << 1;
                    mosi_reg  <= tx_data[DATA_W-1];
                end
            end else if (state_reg == ST_DONE) begin
                mosi_reg <= 1'b0;
            end else if (shift_stb) begin
                mosi_reg  <= tx_sr_reg[DATA_W-1];
                tx_sr_reg <= {tx_sr_reg[DATA_W-2:0], 1'b0};
            end
            if (sample_stb) begin
                rx_sr_reg <= {rx_sr_reg[DATA_W-2:0], miso_bit};
            end
            if ((state_reg == ST_HOLD) && tick) begin
                rx_data_reg <= rx_sr_reg;
            end
        end
    end

    assign mosi    = mosi_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign rx_data = rx_data_reg;

endmodule

// File: tb/tb_spi_master_multi.sv
// Randomised bench for spi_master_multi: a cycle-count frame model plus an SPI
// slave that serves a word and captures mosi, compared every clock.
module tb_spi_master_multi;

    localparam int DW = 16;
    localparam int NS = 3;
    localparam int CD = 2;
    localparam int D  = 1 + CD * (2 * DW + 2);

    logic          clk = 1'b0;
    logic          rst, start, cpol, cpha;
    logic [1:0]    slave_sel;
    logic [DW-1:0] tx_data;
    logic [NS-1:0] miso = '0;
    logic          sclk, mosi, busy, done;
    logic [NS-1:0] cs_n;
    logic [DW-1:0] rx_data;

    spi_master_multi #(.DATA_W(DW), .N_SLAVES(NS), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .start(start), .slave_sel(slave_sel),
        .cpol(cpol), .cpha(cpha), .tx_data(tx_data), .miso(miso),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done),
        .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Words each slave returns in its next frame.
    logic [DW-1:0] slave_words [NS];

    // Frame model: m_t counts cycles since the accepted start (0 = idle).
    int            m_t = 0;
    int            m_sel = 0;
    logic          m_cpol = 1'b0;
    logic          m_cpha = 1'b0;
    logic [DW-1:0] m_tx = '0;
    logic [DW-1:0] m_word = '0;
    logic [DW-1:0] exp_rx = '0;

    // Slave bus-functional model state.
    logic          s_active = 1'b0;
    int            s_idx = 0;
    int            s_ptr = 0;
    logic          s_bit = 1'b0;
    logic          s_prev_sclk = 1'b0;
    logic [DW-1:0] s_cap = '0;

    always @(negedge clk) begin
        int   idx;
        logic lead;
        idx = -1;
        for (int i = 0; i < NS; i++) if (cs_n[i] === 1'b0) idx = i;
        miso = NS'($urandom);
        if (idx >= 0 && !s_active) begin
            s_active = 1'b1;
            s_idx    = idx;
            s_ptr    = DW - 1;
            s_cap    = '0;
            s_bit    = 1'($urandom);
            if (!m_cpha) begin
                s_bit = slave_words[s_idx][s_ptr];
                s_ptr--;
            end
        end else if (idx >= 0 && sclk !== s_prev_sclk) begin
            lead = (sclk != m_cpol);
            if (lead == !m_cpha) begin
                s_cap = {s_cap[DW-2:0], mosi};
            end else if (s_ptr >= 0) begin
                s_bit = slave_words[s_idx][s_ptr];
                s_ptr--;
            end
        end
        if (idx < 0) s_active = 1'b0;
        s_prev_sclk = sclk;
        if (s_active) miso[s_idx] = s_bit;
    end

    // Compare process: check this cycle against the model, then advance it.
    logic [NS-1:0] exp_cs;
    logic          exp_sclk;
    int            k;
    always @(negedge clk) begin
        if (m_t == D) exp_rx = m_word;
        exp_cs   = '1;
        exp_sclk = m_cpol;
        if (m_t >= 1 && m_t < D) exp_cs[m_sel] = 1'b0;
        if (m_t > CD && m_t <= CD + 2 * DW * CD) begin
            k = m_t - CD - 1;
            exp_sclk = m_cpol ^ (((k / CD) % 2) == 0);
        end
        if (cyc > 0) begin
            chk("busy", busy, m_t != 0);
            chk("done", done, m_t == D);
            chk("cs_n", cs_n, exp_cs);
            chk("sclk", sclk, exp_sclk);
            chk("rx_data", rx_data, exp_rx);
            if (m_t == 0) chk("mosi_idle", mosi, 1'b0);
            if (m_t == D) chk("mosi_word", s_cap, m_tx);
        end
        if (rst) begin
            m_t = 0; m_cpol = 1'b0; m_cpha = 1'b0; exp_rx = '0;
        end else if (m_t == 0) begin
            if (start && slave_sel < NS) begin
                m_t = 1; m_sel = int'(slave_sel); m_cpol = cpol; m_cpha = cpha;
                m_tx = tx_data; m_word = slave_words[slave_sel];
            end
        end else if (m_t == D) begin
            m_t = 0;
        end else begin
            m_t++;
        end
    end

    task automatic pulse_start(input int sel, input logic pol, input logic pha,
                               input logic [DW-1:0] tx, output int c0);
        @(posedge clk); #1;
        start = 1'b1; slave_sel = 2'(sel); cpol = pol; cpha = pha; tx_data = tx;
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: actual none, expected done within %0d cycles", budget);
        end
    endtask

    task automatic log_frame(input string tag, input int c0, input int at);
        $display("%s sel=%0d mode=%0d tx=%h rx=%h latency=%0d", tag, m_sel,
                 int'({m_cpol, m_cpha}), m_tx, rx_data, at - c0);
    endtask

    initial begin
        int c0, at, sel, n;
        logic [DW-1:0] w0, w2, tx;
        rst = 1'b1; start = 1'b0; slave_sel = '0; cpol = 1'b0; cpha = 1'b0; tx_data = '0;
        for (int i = 0; i < NS; i++) slave_words[i] = DW'($urandom);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", cs_n, 3'b111);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rx", rx_data, 16'h0000);
        chk("rst_sclk", sclk, 1'b0);

        // Mode 0 reference frame, then modes 1..3 with identical data.
        slave_words[1] = 16'h3C5A;
        for (int m = 0; m < 4; m++) begin
            pulse_start(1, m[1], m[0], 16'hA5C3, c0);
            wait_done(200, at);
            chk("latency", at - c0, 69);
            chk("rx_fixed", rx_data, 16'h3C5A);
            chk("mosi_fixed", s_cap, 16'hA5C3);
            log_frame("frame", c0, at);
        end

        // Start during a frame with different inputs must be ignored.
        pulse_start(1, 1'b0, 1'b0, 16'hA5C3, c0);
        repeat (10) @(posedge clk);
        #1 start = 1'b1; slave_sel = 2'd0; cpol = 1'b1; cpha = 1'b1; tx_data = 16'hFFFF;
        @(posedge clk); #1 start = 1'b0;
        wait_done(200, at);
        chk("ignored_rx", rx_data, 16'h3C5A);
        chk("ignored_mosi", s_cap, 16'hA5C3);
        log_frame("frame_with_ignored_start", c0, at);

        // Out-of-range slave index is dropped.
        pulse_start(3, 1'b0, 1'b0, 16'h1234, c0);
        repeat (6) @(negedge clk);
        chk("badsel_busy", busy, 1'b0);
        chk("badsel_cs_n", cs_n, 3'b111);
        $display("dropped start sel=3 busy=%b cs_n=%b", busy, cs_n);

        // Reset at cycle 20 of a frame aborts it.
        pulse_start(2, 1'b1, 1'b0, 16'h0F0F, c0);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", cs_n, 3'b111);
        chk("abort_sclk", sclk, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rx", rx_data, 16'h0000);
        $display("reset abort at cycle %0d cs_n=%b busy=%b", cyc - c0 - 1, cs_n, busy);
        repeat (80) @(negedge clk);

        // Back-to-back frames: sel 0 then sel 2, second start right after done.
        w0 = DW'($urandom); w2 = DW'($urandom);
        slave_words[0] = w0; slave_words[2] = w2;
        pulse_start(0, 1'b0, 1'b1, DW'($urandom), c0);
        wait_done(200, at);
        chk("b2b_rx0", rx_data, 32'(w0));
        log_frame("frame_b2b_first", c0, at);
        pulse_start(2, 1'b1, 1'b1, DW'($urandom), c0);
        chk("b2b_accept", c0 - at, 1);
        @(negedge clk);
        chk("b2b_busy", busy, 1'b1);
        wait_done(200, at);
        chk("b2b_rx2", rx_data, 32'(w2));
        log_frame("frame_b2b_second", c0, at);

        // Random frames, some with stray starts mid-flight.
        for (int f = 0; f < 12; f++) begin
            sel = $urandom_range(0, 3);
            for (int i = 0; i < NS; i++) slave_words[i] = DW'($urandom);
            tx = DW'($urandom);
            pulse_start(sel, 1'($urandom), 1'($urandom), tx, c0);
            if (sel < NS) begin
                if ($urandom_range(0, 1) == 1) begin
                    n = $urandom_range(3, 40);
                    repeat (n) @(posedge clk);
                    #1 start = 1'b1; slave_sel = 2'($urandom); cpol = 1'($urandom);
                    cpha = 1'($urandom); tx_data = DW'($urandom);
                    @(posedge clk); #1 start = 1'b0;
                end
                wait_done(200, at);
                log_frame("frame_rand", c0, at);
            end else begin
                repeat (5) @(negedge clk);
                $display("dropped start sel=%0d busy=%b", sel, busy);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_multi.md
SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 Parameter DATA_W, default 16, frame width in bits (>=2).
REQ-002 Parameter N_SLAVES, default 3, number of chip-select/MISO lanes (>=1).
REQ-003 Parameter CLK_DIV, default 4, SCLK half-period in clk cycles (>=1).
REQ-004 The block SHALL have one clock and a synchronous active-high reset, as listed below.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous to clk, active-high.
REQ-007 start  input  1  single-cycle request to begin a frame.
REQ-008 slave_sel  input  $clog2(N_SLAVES) (min 1)  target slave index.
REQ-009 cpol  input  1  SCLK idle level for the frame.
REQ-010 cpha  input  1  SPI clock phase for the frame.
REQ-011 tx_data  input  DATA_W  word to transmit.
REQ-012 miso  input  N_SLAVES  per-slave serial input.
REQ-013 sclk  output  1  serial clock.
REQ-014 mosi  output  1  serial output, MSB first.
REQ-015 cs_n  output  N_SLAVES  active-low chip selects.
REQ-016 busy  output  1  high while a frame is in progress.
REQ-017 done  output  1  one-cycle pulse at frame end.
REQ-018 rx_data  output  DATA_W  last received word.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, XFER, HOLD and DONE.
REQ-020 IDLE: start=1 with slave_sel<N_SLAVES latches tx_data, slave_sel, cpol and cpha, then moves to SETUP; the start cycle is cycle 0.
REQ-021 start with slave_sel>=N_SLAVES SHALL be dropped: no state change, no busy, no done.
REQ-022 start while busy=1 SHALL be ignored; later changes to the inputs SHALL NOT affect the frame in flight.
REQ-023 cs_n[sel] SHALL be low from cycle 1 through the last HOLD cycle; all other cs_n bits SHALL stay high.
REQ-024 SETUP SHALL last CLK_DIV cycles with sclk=cpol.
REQ-025 XFER SHALL last 2*DATA_W*CLK_DIV cycles, and sclk SHALL toggle every CLK_DIV cycles (2*DATA_W edges).
REQ-026 cpha=0: mosi SHALL present the MSB on entering SETUP; miso[sel] is sampled on each leading edge and mosi shifts on each trailing edge.
REQ-027 cpha=1: mosi SHALL shift on each leading edge (the MSB appears at the first leading edge), and miso[sel] is sampled on each trailing edge.
REQ-028 HOLD SHALL last CLK_DIV cycles with sclk=cpol.
REQ-029 DONE SHALL last one cycle: cs_n all high, done=1, and rx_data updated with the DATA_W sampled bits (first sample = MSB); then return to IDLE.
REQ-030 busy SHALL be high from cycle 1 through the DONE cycle; done is therefore at cycle 2 + CLK_DIV*(2*DATA_W+2) - 1.
REQ-031 A new start is accepted in the cycle after DONE (back-to-back frames).
REQ-032 rx_data SHALL hold its value between DONE pulses.
REQ-033 mosi SHALL be 0 in IDLE.

Reset
REQ-034 rst=1 SHALL force IDLE, sclk=0, mosi=0, cs_n all ones, busy=0, done=0, rx_data=0, and clear the latched mode, shift registers and counters.
REQ-035 rst asserted mid-frame SHALL abort the frame in the same edge, with no done pulse; the outputs follow REQ-034.

Structure
REQ-036 The shared package spi_pkg SHALL hold the FSM state typedef and the CPOL/CPHA mode encoding.
REQ-037 The sub-module spi_clk_gen SHALL hold the CLK_DIV divider and produce the leading/trailing edge strobes and sclk; the FSM, shift registers and cs decode stay in spi_master_multi.

Verification (DATA_W=16, N_SLAVES=3, CLK_DIV=2)
REQ-038 Mode 0, sel=1, tx=16'hA5C3, slave 1 returns 16'h3C5A -> mosi bitstream A5C3, rx_data=16'h3C5A, done at cycle 69, only cs_n[1] low.
REQ-039 Modes 1, 2 and 3 with the same data -> identical rx_data; sclk idles at cpol; sampling on the edge given by REQ-026/REQ-027.
REQ-040 start asserted again during a frame with different tx_data -> ignored; the first frame completes unchanged.
REQ-041 start with sel=3 -> busy stays 0, cs_n=3'b111, no done.
REQ-042 rst at cycle 20 of a frame -> next cycle cs_n=3'b111, sclk=0, busy=0, rx_data=0, no done.
REQ-043 Two frames back-to-back to sel 0 then sel 2 -> second start accepted the cycle after the first done; both rx_data values correct.
